// File: rtl/next_pc_unit_pkg.sv
// next_pc_unit_pkg: shared BTB entry type, counter encodings and target arithmetic
package next_pc_unit_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
   typedef enum logic [1:0] {UPD_BR_T, UPD_BR_NT, UPD_JMP} upd_e;
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      ctr_e        ctr;
   } btb_entry_t;
   function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
      return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction
   function automatic logic [31:0] jmp_target(input logic [31:0] pc, input logic [25:0] jidx);
      return ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, jidx, 2'b00};
   endfunction
   function automatic ctr_e ctr_step(input ctr_e c, input logic up);
      return up ? (c == ST ? ST : ctr_e'(c + 2'd1)) : (c == SNT ? SNT : ctr_e'(c - 2'd1));
   endfunction
endpackage

// File: rtl/next_pc_unit_btb.sv
// btb_array: branch target buffer storage, combinational lookup and read-modify-write training port
module btb_array
   import next_pc_unit_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] ridx,
   input  logic [31:0]      rtag,
   output logic             rtaken,
   output logic [31:0]      rtarget,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [31:0]      wtag,
   input  logic [31:0]      wtarget,
   input  upd_e             wop
);
   btb_entry_t mem [2**IDX_W];
   btb_entry_t cur, nxt;
   logic whit, alloc, up;
   assign rtaken  = mem[ridx].valid && mem[ridx].tag == rtag && mem[ridx].ctr[1];
   assign rtarget = mem[ridx].target;
   assign cur   = mem[widx];
   assign whit  = cur.valid && cur.tag == wtag;
   assign up    = wop == UPD_BR_T;
   // jumps always (re)allocate; branches allocate only on a taken miss
   assign alloc = wop == UPD_JMP || (up && !whit);
   assign nxt = alloc ? '{valid: 1'b1, tag: wtag, target: wtarget, ctr: (wop == UPD_JMP ? ST : WT)}
                      : '{valid: cur.valid, tag: cur.tag, target: (up ? wtarget : cur.target),
                          ctr: (whit ? ctr_step(cur.ctr, up) : cur.ctr)};
   always_ff @(posedge clk)
      if (!rst_n)
         for (int i = 0; i < 2**IDX_W; i++) mem[i] <= '0;
      else if (we)
         mem[widx] <= nxt;
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: IF program counter with BTB prediction, ID-stage resolution and redirect
module next_pc_unit
   import next_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          BTB_IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic        id_is_branch,
   input  logic        id_is_jump,
   input  logic        id_is_jr,
   input  logic [15:0] id_imm16,
   input  logic [25:0] id_jidx,
   input  logic [31:0] id_rs_val,
   input  logic        br_true,
   input  logic        id_pred_taken,
   input  logic [31:0] id_pred_target,
   output logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target,
   output logic        flush_ifid,
   output logic        mispredict
);
   localparam int TS = BTB_IDX_W + 2;
   logic [31:0] pc, tgt;
   logic res, taken, we;
   upd_e wop;
   assign if_pc      = pc;
   assign res        = id_valid && !stall && (id_is_branch || id_is_jump || id_is_jr);
   assign taken      = id_is_jump || id_is_jr || (id_is_branch && br_true);
   assign tgt        = id_is_jr ? id_rs_val : id_is_jump ? jmp_target(id_pc, id_jidx) : br_target(id_pc, id_imm16);
   assign mispredict = res && (taken != id_pred_taken || (taken && id_pred_target != tgt));
   assign flush_ifid = mispredict;
   // jr targets are register-dependent, so they never train the BTB
   assign we  = res && !id_is_jr && (id_is_branch || id_is_jump);
   assign wop = id_is_jump ? UPD_JMP : br_true ? UPD_BR_T : UPD_BR_NT;
   btb_array #(.IDX_W(BTB_IDX_W)) u_btb (
      .clk     (clk),
      .rst_n   (rst_n),
      .ridx    (pc[TS-1:2]),
      .rtag    (pc >> TS),
      .rtaken  (if_pred_taken),
      .rtarget (if_pred_target),
      .we      (we),
      .widx    (id_pc[TS-1:2]),
      .wtag    (id_pc >> TS),
      .wtarget (tgt),
      .wop     (wop)
   );
   always_ff @(posedge clk)
      if (!rst_n)
         pc <= RESET_PC;
      else if (!stall)
         pc <= mispredict ? (taken ? tgt : id_pc + 32'd4) : if_pred_taken ? if_pred_target : pc + 32'd4;
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed plan plus randomized stimulus against a behavioural PC/BTB model
module tb_next_pc_unit;
   logic clk = 0, rst_n = 0, stall = 0, id_valid = 0, id_is_branch = 0, id_is_jump = 0, id_is_jr = 0;
   logic br_true = 0, id_pred_taken = 0;
   logic [31:0] id_pc = 0, id_rs_val = 0, id_pred_target = 0;
   logic [15:0] id_imm16 = 0;
   logic [25:0] id_jidx = 0;
   logic [31:0] if_pc, if_pred_target;
   logic if_pred_taken, flush_ifid, mispredict;
   int vecs = 0, errs = 0;
   logic live = 0;
   logic mv [16] = '{default: 1'b0};
   logic [31:0] mtag [16], mtgt [16];
   int mctr [16];
   logic [31:0] mpc = 32'h0;
   logic [31:0] pcs [6] = '{32'h10, 32'h14, 32'h40, 32'h410, 32'h1000_0010, 32'h24};
   logic [31:0] p;
   int k;

   always #5 clk = ~clk;

   next_pc_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
      .id_is_branch(id_is_branch), .id_is_jump(id_is_jump), .id_is_jr(id_is_jr),
      .id_imm16(id_imm16), .id_jidx(id_jidx), .id_rs_val(id_rs_val), .br_true(br_true),
      .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target), .if_pc(if_pc),
      .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
      .flush_ifid(flush_ifid), .mispredict(mispredict)
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      vecs++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   function automatic logic [31:0] actual_target();
      if (id_is_jr) return id_rs_val;
      if (id_is_jump) return ((id_pc + 32'd4) & 32'hF000_0000) | (32'(id_jidx) << 2);
      return id_pc + 32'd4 + (32'($signed(id_imm16)) << 2);
   endfunction

   function automatic logic was_taken();
      return id_is_jump || id_is_jr || (id_is_branch && br_true);
   endfunction

   function automatic logic exp_mis();
      logic r;
      r = id_valid && !stall && (id_is_branch || id_is_jump || id_is_jr);
      return r && (was_taken() != id_pred_taken || (was_taken() && id_pred_target != actual_target()));
   endfunction

   task automatic train();
      int j;
      logic h;
      j = int'((id_pc >> 2) % 16);
      h = mv[j] && mtag[j] == id_pc / 64;
      if (id_is_jump) begin
         mv[j] = 1; mtag[j] = id_pc / 64; mtgt[j] = actual_target(); mctr[j] = 3;
      end else if (h) begin
         if (br_true) begin
            mctr[j] = mctr[j] == 3 ? 3 : mctr[j] + 1;
            mtgt[j] = actual_target();
         end else
            mctr[j] = mctr[j] == 0 ? 0 : mctr[j] - 1;
      end else if (br_true) begin
         mv[j] = 1; mtag[j] = id_pc / 64; mtgt[j] = actual_target(); mctr[j] = 2;
      end
   endtask

   // called at a falling edge with inputs already applied; returns at the next falling edge
   task automatic cyc();
      int i;
      logic pt, mis;
      logic [31:0] nxt;
      #1;
      i = int'((mpc >> 2) % 16);
      pt = mv[i] && mtag[i] == mpc / 64 && mctr[i] >= 2;
      mis = exp_mis();
      if (live) begin
         chk("if_pc", if_pc, mpc);
         chk("if_pred_taken", if_pred_taken, pt);
         if (pt) chk("if_pred_target", if_pred_target, mtgt[i]);
         chk("mispredict", mispredict, mis);
         chk("flush_ifid", flush_ifid, mis);
      end
      nxt = !rst_n ? 32'h0 : stall ? mpc : mis ? (was_taken() ? actual_target() : id_pc + 32'd4)
          : pt ? mtgt[i] : mpc + 32'd4;
      @(posedge clk);
      mpc = nxt;
      if (!rst_n) begin
         for (int m = 0; m < 16; m++) mv[m] = 0;
         live = 1;
      end else if (id_valid && !stall && !id_is_jr && (id_is_branch || id_is_jump))
         train();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; id_is_branch = 0; id_is_jump = 0; id_is_jr = 0; br_true = 0;
      id_pred_taken = 0; id_pred_target = 0; stall = 0;
   endtask

   task automatic set_br(input logic [31:0] pc, input logic [15:0] imm, input logic t,
                         input logic pt, input logic [31:0] ptgt);
      id_valid = 1; id_is_branch = 1; id_is_jump = 0; id_is_jr = 0;
      id_pc = pc; id_imm16 = imm; br_true = t; id_pred_taken = pt; id_pred_target = ptgt;
   endtask

   task automatic set_jr(input logic [31:0] pc, input logic [31:0] rs);
      id_valid = 1; id_is_branch = 0; id_is_jump = 0; id_is_jr = 1;
      id_pc = pc; id_rs_val = rs; br_true = 0; id_pred_taken = 0; id_pred_target = 0;
   endtask

   initial begin
      @(negedge clk);
      rst_n = 0; cyc(); cyc();
      chk("reset_pc", if_pc, 32'h0);
      chk("reset_pred", if_pred_taken, 1'b0);
      chk("reset_flush", flush_ifid, 1'b0);
      rst_n = 1; cyc();
      chk("pc_plus4", if_pc, 32'h4);
      set_br(32'h10, 16'h0004, 1, 0, 0); #1;
      chk("cold_mis", mispredict, 1'b1);
      chk("cold_flush", flush_ifid, 1'b1);
      cyc();
      chk("cold_redirect", if_pc, 32'h24);
      set_jr(32'h80, 32'h10); cyc();
      chk("jr_to_10", if_pc, 32'h10);
      idle(); #1;
      chk("warm_pred", if_pred_taken, 1'b1);
      chk("warm_tgt", if_pred_target, 32'h24);
      cyc();
      chk("warm_next", if_pc, 32'h24);
      set_br(32'h10, 16'h0004, 1, 1, 32'h24); #1;
      chk("warm_nomis", mispredict, 1'b0);
      cyc();
      set_br(32'h10, 16'h0004, 0, 1, 32'h24); #1;
      chk("nt1_mis", mispredict, 1'b1);
      cyc();
      chk("nt1_redirect", if_pc, 32'h14);
      set_br(32'h10, 16'h0004, 0, 1, 32'h24); #1;
      chk("nt2_mis", mispredict, 1'b1);
      cyc();
      set_jr(32'h80, 32'h10); cyc();
      idle(); #1;
      chk("nt_pred", if_pred_taken, 1'b0);
      set_br(32'h10, 16'h0004, 1, 0, 0); stall = 1;
      p = if_pc;
      repeat (3) begin
         #1 chk("stall_nomis", mispredict, 1'b0);
         cyc();
         chk("stall_hold", if_pc, p);
      end
      stall = 0; #1;
      chk("unstall_mis", mispredict, 1'b1);
      cyc();
      chk("unstall_redirect", if_pc, 32'h24);
      set_jr(32'h40, 32'h400); #1;
      chk("jr_mis", mispredict, 1'b1);
      cyc();
      chk("jr_redirect", if_pc, 32'h400);
      set_jr(32'h80, 32'h40); cyc();
      idle(); #1;
      chk("jr_noalloc", if_pred_taken, 1'b0);
      rst_n = 0; set_br(32'h10, 16'h0004, 1, 0, 0); stall = 1; cyc();
      chk("midrst_pc", if_pc, 32'h0);
      rst_n = 1; stall = 0; set_jr(32'h80, 32'h10); cyc();
      idle(); #1;
      chk("rst_cleared", if_pred_taken, 1'b0);
      repeat (3000) begin
         idle();
         k = $urandom_range(0, 9);
         rst_n = $urandom_range(0, 99) != 0;
         stall = $urandom_range(0, 4) == 0;
         id_valid = $urandom_range(0, 4) != 0;
         id_pc = pcs[$urandom_range(0, 5)];
         id_is_branch = k < 5;
         id_is_jump = k == 5 || k == 6;
         id_is_jr = k == 7;
         id_imm16 = 16'($urandom_range(0, 15)) - 16'd8;
         id_jidx = 26'($urandom_range(0, 31));
         id_rs_val = pcs[$urandom_range(0, 5)];
         br_true = 1'($urandom_range(0, 1));
         id_pred_taken = 1'($urandom_range(0, 1));
         id_pred_target = $urandom_range(0, 1) ? actual_target() : pcs[$urandom_range(0, 5)];
         cyc();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
